recv_serial: RTL and testbench

UART receiver (8N1, LSB first) that deserialises the host-to-FPGA serial line into bytes; the receive-side counterpart of `send_serial`. Sits between the board's UART input pin and the byte consumer in `top`, sharing the `WAIT_DIV` bit-timing convention with `send_serial` so both directions run at the same baud rate. It produces a one-cycle `valid` strobe per good frame and a one-cycle `frame_err` strobe per bad stop bit.

---
 rtl/recv_serial.sv | 133 +++++++++++++
 tb/tb_recv_serial.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/recv_serial.sv
// recv_serial: 8N1 UART receiver, LSB first.
// Deserialises the host-to-FPGA serial line into bytes and uses the same
// WAIT_DIV bit-timing convention as send_serial.
//
// Parameters:
//   WAIT_DIV     clock cycles per bit (>= 4)
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   uart_txd_in  asynchronous serial input, idle high
//   data_out     last correctly received byte, held until the next good frame
//   valid        one-cycle strobe, data_out is new in the same cycle
//   frame_err    one-cycle strobe, stop bit was sampled low
//   busy         high while a frame is in progress (START, DATA, STOP)
module recv_serial #(
  parameter int unsigned WAIT_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_txd_in,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned   CW      = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(WAIT_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(WAIT_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_BREAK,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_txd_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BREAK;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        // Line must return high before a new start bit is accepted.
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        // Re-check the start bit half a bit in; a high line means a glitch.
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Stop bit is sampled mid-bit, so IDLE is re-entered half a bit
        // early and a directly following start bit is not missed.
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_BREAK;
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_recv_serial.sv
// Self-checking bench for recv_serial with WAIT_DIV = 5.
// Every cycle of every phase is compared against a waveform-level reference
// model; frame-level tables and hand-written sequences add fixed expectations.
module tb_recv_serial;

  localparam int unsigned W    = 5;
  localparam int unsigned H    = W / 2;
  localparam int unsigned MAXC = 4096;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       line = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  recv_serial #(.WAIT_DIV(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_txd_in(line),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Per-phase logs: pin value applied before edge k, outputs seen after edge k.
  logic       pin_log [MAXC];
  logic       obs_v   [MAXC];
  logic       obs_e   [MAXC];
  logic       obs_b   [MAXC];
  logic [7:0] obs_d   [MAXC];
  logic       exp_v   [MAXC];
  logic       exp_e   [MAXC];
  logic       exp_b   [MAXC];
  logic [7:0] exp_byte[MAXC];
  int unsigned ncyc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned gap;
    int unsigned hold;
    logic        ok;
    logic [7:0]  exp_d;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic drive(input logic v);
    line = v;
    if (ncyc < MAXC) pin_log[ncyc] = v;
    @(posedge clk);
    #1;
    if (ncyc < MAXC) begin
      obs_v[ncyc] = valid;
      obs_e[ncyc] = frame_err;
      obs_b[ncyc] = busy;
      obs_d[ncyc] = data_out;
    end
    ncyc++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int unsigned gap, input int unsigned hold);
    repeat (gap) drive(1'b1);
    repeat (W) drive(1'b0);
    for (int unsigned i = 0; i < 8; i++) repeat (W) drive(d[i]);
    repeat (W) drive(stop);
    repeat (hold) drive(1'b0);
  endtask

  // Reset is asserted immediately and checked before any clock edge.
  task automatic start_phase(input logic line_at_release);
    rst  = 1'b0;
    line = line_at_release;
    #1;
    check("reset_outputs", {21'd0, data_out, valid, frame_err, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    ncyc = 0;
  endtask

  // Line value the receiver acts on at edge k: pin delayed two cycles,
  // high before that because the synchroniser resets high.
  function automatic logic rx_at(input int unsigned k, input int unsigned len);
    if (k < 2) return 1'b1;
    if (k - 2 < len) return pin_log[k - 2];
    return 1'b1;
  endfunction

  // Reference: scan the waveform for start positions and sample at the
  // fixed offsets T0+H, T0+H+(i+1)W, T0+H+9W.
  task automatic model_check(input int unsigned len, input string tag);
    int unsigned n, t0, s, sp;
    logic        brk;
    logic [7:0]  b;
    logic [7:0]  d;
    for (int unsigned k = 0; k < len; k++) begin
      exp_v[k] = 1'b0; exp_e[k] = 1'b0; exp_b[k] = 1'b0; exp_byte[k] = 8'h00;
    end
    brk = 1'b1;
    n   = 0;
    while (n < len) begin
      if (brk) begin
        if (rx_at(n, len)) brk = 1'b0;
        n++;
      end else if (rx_at(n, len)) begin
        n++;
      end else begin
        t0 = n;
        s  = t0 + H;
        if (rx_at(s, len)) begin
          for (int unsigned k = t0; k < s && k < len; k++) exp_b[k] = 1'b1;
          n = s + 1;
        end else begin
          for (int unsigned i = 0; i < 8; i++) b[i] = rx_at(s + (i + 1) * W, len);
          sp = s + 9 * W;
          for (int unsigned k = t0; k < sp && k < len; k++) exp_b[k] = 1'b1;
          if (sp < len) begin
            if (rx_at(sp, len)) begin
              exp_v[sp]    = 1'b1;
              exp_byte[sp] = b;
            end else begin
              exp_e[sp] = 1'b1;
            end
          end
          brk = !rx_at(sp, len);
          n   = sp + 1;
        end
      end
    end
    d = 8'h00;
    for (int unsigned k = 0; k < len; k++) begin
      if (exp_v[k]) d = exp_byte[k];
      check($sformatf("%s_cyc%0d", tag, k),
            {21'd0, obs_d[k], obs_v[k], obs_e[k], obs_b[k]},
            {21'd0, d, exp_v[k], exp_e[k], exp_b[k]});
    end
  endtask

  task automatic collect(input int unsigned len);
    ev_t e;
    evq.delete();
    for (int unsigned k = 0; k < len; k++) begin
      if (obs_v[k]) begin e.err = 1'b0; e.d = obs_d[k]; evq.push_back(e); end
      if (obs_e[k]) begin e.err = 1'b1; e.d = obs_d[k]; evq.push_back(e); end
    end
  endtask

  function automatic logic [31:0] ev_at(input int unsigned i);
    if (i < evq.size()) return {23'd0, evq[i].err, evq[i].d};
    return 32'hFFFF_FFFF;
  endfunction

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h53, 1'b1, 3, 0,  1'b1, 8'h53};
    tbl[1] = '{8'hA5, 1'b1, 4, 0,  1'b1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 0, 0,  1'b1, 8'h00};
    tbl[3] = '{8'hFF, 1'b0, 2, 20, 1'b0, 8'h00};
    tbl[4] = '{8'h3C, 1'b1, 4, 0,  1'b1, 8'h3C};

    // Table phase: single frame, back-to-back pair, framing error + break.
    ncyc = 0;
    start_phase(1'b1);
    for (int unsigned i = 0; i < 5; i++)
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, tbl[i].hold);
    repeat (3 * W) drive(1'b1);
    model_check(ncyc, "tbl");
    collect(ncyc);
    check("tbl_events", evq.size(), 5);
    for (int unsigned i = 0; i < 5; i++)
      check($sformatf("tbl_ev%0d", i), ev_at(i), {23'd0, !tbl[i].ok, tbl[i].exp_d});
    check("tbl_busy_in_frame", {31'd0, obs_b[3 + 2 + W]}, 32'd1);

    // One-cycle low glitch on an idle line.
    start_phase(1'b1);
    repeat (6) drive(1'b1);
    drive(1'b0);
    repeat (12) drive(1'b1);
    model_check(ncyc, "glitch");
    collect(ncyc);
    check("glitch_events", evq.size(), 0);
    check("glitch_busy_hi", {31'd0, obs_b[6 + 2]}, 32'd1);
    check("glitch_busy_lo", {31'd0, obs_b[6 + H + 3]}, 32'd0);

    // Reset during data bit 4, release with line low briefly, then 0x81.
    start_phase(1'b1);
    repeat (3) drive(1'b1);
    repeat (W) drive(1'b0);
    for (int unsigned i = 0; i < 4; i++) repeat (W) drive(i[0]);
    repeat (2) drive(1'b0);
    model_check(ncyc, "abort");
    collect(ncyc);
    check("abort_events", evq.size(), 0);
    check("abort_busy", {31'd0, obs_b[ncyc - 1]}, 32'd1);
    start_phase(1'b0);
    drive(1'b0);
    drive(1'b0);
    send_frame(8'h81, 1'b1, 6, 0);
    repeat (2 * W + 5) drive(1'b1);
    model_check(ncyc, "after_rst");
    collect(ncyc);
    check("after_rst_events", evq.size(), 1);
    check("after_rst_ev0", ev_at(0), {23'd0, 1'b0, 8'h81});

    // Randomised traffic: frames, bad stop bits, breaks and short glitches.
    start_phase(1'b1);
    for (int unsigned f = 0; f < 24; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 4)) drive(1'b1);
        repeat ($urandom_range(1, H + 1)) drive(1'b0);
        repeat ($urandom_range(1, 6)) drive(1'b1);
      end else begin
        logic stop_ok;
        stop_ok = ($urandom_range(0, 7) != 0);
        send_frame(8'($urandom), stop_ok, $urandom_range(0, 6),
                   stop_ok ? 0 : $urandom_range(0, 12));
        if (!stop_ok) drive(1'b1);
      end
    end
    repeat (12 * W) drive(1'b1);
    model_check(ncyc, "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
